axis_fifo_downsizer: RTL and testbench
======================================

AXIS_FIFO_DOWNSIZER -- requirements
Module: axis_fifo_downsizer

Interface
REQ-001 SHALL have parameter AXIS_DATA_WIDTH, default 512: read-side tdata width in bits, multiple of 8.
REQ-002 SHALL have parameter AXIS_TUSER_WIDTH, default 256: read-side tuser width per lane.
REQ-003 SHALL have parameter RATIO, default 2: write width / read width, legal values 2, 4, 8.
REQ-004 SHALL have parameter ADDR_WIDTH, default 12: FIFO depth 2**ADDR_WIDTH wide words.
REQ-005 SHALL have port aclk, input, 1: sole clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have ports write_tdata/write_tkeep/write_tuser, input, RATIO x AXIS_DATA_WIDTH, RATIO x AXIS_DATA_WIDTH/8 and RATIO x AXIS_TUSER_WIDTH: wide beat; lane 0 in the LSBs.
REQ-008 SHALL have ports write_tvalid and write_tlast, input, 1 each; write_tready, output, 1.
REQ-009 SHALL have ports read_tdata/read_tkeep/read_tuser, output, AXIS_DATA_WIDTH, AXIS_DATA_WIDTH/8 and AXIS_TUSER_WIDTH: one lane.
REQ-010 SHALL have ports read_tvalid and read_tlast, output, 1 each; read_tready, input, 1.

Function
REQ-011 SHALL store one wide beat (data, keep, user, last) per entry; write accepted when write_tvalid && write_tready.
REQ-012 SHALL use (ADDR_WIDTH+1)-bit write/read pointers: full = MSBs differ && low bits equal; empty = pointers equal.
REQ-013 SHALL drive write_tready = !full and read_tvalid = !empty, both purely from pointers.
REQ-014 SHALL hold a lane index register, range 0..RATIO-1; the read_* data fields are the slice of the head entry at that lane.
REQ-015 SHALL compute last_lane for the head entry: highest lane with non-zero keep when its tlast = 1; 0 if all keep is zero; RATIO-1 when tlast = 0.
REQ-016 SHALL assert read_tlast only when head tlast = 1 and lane == last_lane; lanes above last_lane are never presented.
REQ-017 SHALL, on read handshake, pop the head entry (read pointer +1) and clear lane to 0 when lane == last_lane; otherwise increment lane.
REQ-018 SHALL address RAM with next read pointer (synchronous-read RAM) so a new head entry is presented the cycle after a pop, with no bubble.
REQ-019 SHALL produce first-word latency of 1 cycle: write accepted at cycle N -> read_tvalid at cycle N+1.
REQ-020 SHALL allow a simultaneous push and pop when full: pop frees an entry, but write_tready stays low that cycle (full computed before pop).
REQ-021 SHALL wrap pointers modulo 2**(ADDR_WIDTH+1) without loss; lane index wraps only via pop.
REQ-022 SHALL keep read_* outputs stable while read_tvalid && !read_tready.
REQ-023 SHALL pass tuser lanes unmodified, one lane per narrow beat.

Reset
REQ-024 SHALL, while reset = 1 at a clock edge, clear both pointers and lane to 0; next cycle read_tvalid = 0 and write_tready = 1.
REQ-025 SHALL discard all stored entries on reset asserted mid-packet; no partial beat is emitted afterwards.
REQ-026 SHALL NOT reset RAM contents; read_tdata/tkeep/tuser/tlast are don't-care while read_tvalid = 0.

Configuration
REQ-027 SHALL, with AXIS_FIFO_DOWNSIZER_COUNT_EN defined, add output count [ADDR_WIDTH:0] = write_ptr - read_ptr (stored wide entries), registered and cleared to 0 by reset.
REQ-028 SHALL, without AXIS_FIFO_DOWNSIZER_COUNT_EN, have no count port and no count logic.

Structure
REQ-029 SHALL take legal RATIO values and the lane-index width (log2 RATIO) from the shared axis package; tkeep width is derived, not a parameter.
REQ-030 SHALL instantiate the existing ram_w as its single sub-module, width RATIO x (data + keep + user) + 1.

Verification (AXIS_DATA_WIDTH=64, RATIO=4, ADDR_WIDTH=2)
REQ-031 SHALL check: one beat, tlast=1, keep 0x00_00_FF_FF (lanes 0,1 full) -> exactly 2 narrow beats, tlast on the 2nd, keep 0xFF each.
REQ-032 SHALL check: 3 beats, tlast on the 3rd with keep all-ones, read_tready held 1 -> 12 narrow beats back-to-back, no bubble, tlast only on the 12th.
REQ-033 SHALL check: 4 beats with read_tready=0 -> write_tready=0 after the 4th; 5th beat held until first pop; with COUNT_EN, count = 4.
REQ-034 SHALL check: read_tready toggling 1/0 each cycle -> outputs stable during stalls, lane order 0,1,2,3 preserved.
REQ-035 SHALL check: reset pulsed after 2 of 4 lanes read -> read_tvalid = 0 next cycle; the next packet starts at lane 0.
REQ-036 SHALL check: tlast beat with keep all-zero -> one narrow beat, read_tlast=1, read_tkeep=0.

Source files
------------

// File: rtl/axis_fifo_downsizer_pkg.sv
// Shared AXI-Stream helpers for the wide-to-narrow FIFO.
// Holds the legal write/read width ratios and the lane index width.
package axis_fifo_downsizer_pkg;

    localparam int AXIS_RATIO_MIN = 2;
    localparam int AXIS_RATIO_MAX = 8;

    function automatic bit axis_ratio_legal(input int ratio);
        return (ratio == 2) || (ratio == 4) || (ratio == 8);
    endfunction

    function automatic int axis_lane_width(input int ratio);
        return (ratio >= 8) ? 3 : (ratio >= 4) ? 2 : 1;
    endfunction

endpackage

// File: rtl/axis_fifo_downsizer_ram_w.sv
// Simple dual-port RAM with registered read for the downsizer FIFO.
// A write to the address being read returns the new word (write-first).
module ram_w
    import axis_fifo_downsizer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);

    logic [WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        // Bypass lets a beat written into an empty FIFO appear next cycle
        if (i_we && (i_waddr == i_raddr)) begin
            o_rdata <= i_wdata;
        end else begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/axis_fifo_downsizer.sv
// AXI-Stream FIFO storing wide beats and emitting them one lane at a time.
// Define AXIS_FIFO_DOWNSIZER_COUNT_EN to add the registered 'count' output.
module axis_fifo_downsizer
    import axis_fifo_downsizer_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH  = 512,
    parameter int AXIS_TUSER_WIDTH = 256,
    parameter int RATIO            = 2,
    parameter int ADDR_WIDTH       = 12
) (
    input  logic                                 aclk,
    input  logic                                 reset,
    input  logic [RATIO*AXIS_DATA_WIDTH-1:0]     write_tdata,
    input  logic [RATIO*AXIS_DATA_WIDTH/8-1:0]   write_tkeep,
    input  logic [RATIO*AXIS_TUSER_WIDTH-1:0]    write_tuser,
    input  logic                                 write_tvalid,
    input  logic                                 write_tlast,
    output logic                                 write_tready,
    output logic [AXIS_DATA_WIDTH-1:0]           read_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0]         read_tkeep,
    output logic [AXIS_TUSER_WIDTH-1:0]          read_tuser,
    output logic                                 read_tvalid,
    output logic                                 read_tlast,
    input  logic                                 read_tready
`ifdef AXIS_FIFO_DOWNSIZER_COUNT_EN
    ,
    output logic [ADDR_WIDTH:0]                  count
`endif
);

    localparam int KW     = AXIS_DATA_WIDTH / 8;
    localparam int LANE_W = axis_ratio_legal(RATIO) ?
                            axis_lane_width(RATIO) : 1;
    localparam int DATA_W = RATIO * AXIS_DATA_WIDTH;
    localparam int KEEP_W = RATIO * KW;
    localparam int USER_W = RATIO * AXIS_TUSER_WIDTH;
    localparam int RAM_W  = DATA_W + KEEP_W + USER_W + 1;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [LANE_W-1:0]   LANE_ONE = LANE_W'(1);

    logic [ADDR_WIDTH:0]   r_wptr;
    logic [ADDR_WIDTH:0]   r_rptr;
    logic [ADDR_WIDTH:0]   w_wptr_next;
    logic [ADDR_WIDTH:0]   w_rptr_next;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic [LANE_W-1:0]     r_lane;
    logic [LANE_W-1:0]     w_last_lane;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_rd_hs;
    logic                  w_at_last;
    logic                  w_pop;
    logic [RAM_W-1:0]      w_wdata;
    logic [RAM_W-1:0]      w_head;
    logic [DATA_W-1:0]     w_head_data;
    logic [KEEP_W-1:0]     w_head_keep;
    logic [USER_W-1:0]     w_head_user;
    logic                  w_head_last;

    assign w_full  = (r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH]) &&
                     (r_wptr[ADDR_WIDTH-1:0] == r_rptr[ADDR_WIDTH-1:0]);
    assign w_empty = (r_wptr == r_rptr);

    assign write_tready = !w_full;
    assign read_tvalid  = !w_empty;

    assign w_push    = write_tvalid && !w_full;
    assign w_rd_hs   = read_tvalid && read_tready;
    assign w_at_last = (r_lane == w_last_lane);
    assign w_pop     = w_rd_hs && w_at_last;

    assign w_wptr_next = w_push ? r_wptr + PTR_ONE : r_wptr;
    assign w_rptr_next = w_pop  ? r_rptr + PTR_ONE : r_rptr;
    assign w_raddr     = reset ? '0 : w_rptr_next[ADDR_WIDTH-1:0];

    assign w_wdata = {write_tlast, write_tuser, write_tkeep, write_tdata};

    ram_w #(
        .WIDTH      (RAM_W),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clk   (aclk),
        .i_we    (w_push && !reset),
        .i_waddr (r_wptr[ADDR_WIDTH-1:0]),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_head)
    );

    assign w_head_data = w_head[DATA_W-1:0];
    assign w_head_keep = w_head[DATA_W +: KEEP_W];
    assign w_head_user = w_head[DATA_W+KEEP_W +: USER_W];
    assign w_head_last = w_head[RAM_W-1];

    // Final lane of a tlast beat is its highest lane holding any byte
    always_comb begin
        w_last_lane = LANE_W'(RATIO - 1);
        if (w_head_last) begin
            w_last_lane = '0;
            for (int i = 1; i < RATIO; i++) begin
                if (|w_head_keep[i*KW +: KW]) begin
                    w_last_lane = LANE_W'(i);
                end
            end
        end
    end

    always_comb begin
        read_tdata = w_head_data[AXIS_DATA_WIDTH-1:0];
        read_tkeep = w_head_keep[KW-1:0];
        read_tuser = w_head_user[AXIS_TUSER_WIDTH-1:0];
        for (int i = 1; i < RATIO; i++) begin
            if (r_lane == LANE_W'(i)) begin
                read_tdata = w_head_data[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
                read_tkeep = w_head_keep[i*KW +: KW];
                read_tuser = w_head_user[i*AXIS_TUSER_WIDTH +: AXIS_TUSER_WIDTH];
            end
        end
    end

    assign read_tlast = w_head_last && w_at_last;

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_lane <= '0;
        end else begin
            r_wptr <= w_wptr_next;
            r_rptr <= w_rptr_next;
            if (w_rd_hs) begin
                r_lane <= w_at_last ? '0 : r_lane + LANE_ONE;
            end
        end
    end

`ifdef AXIS_FIFO_DOWNSIZER_COUNT_EN
    logic [ADDR_WIDTH:0] r_count;

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_wptr_next - w_rptr_next;
        end
    end

    assign count = r_count;
`endif

endmodule

// File: tb/tb_axis_fifo_downsizer.sv
// Bench for axis_fifo_downsizer: table rows, directed corners, random traffic.
// Expected narrow beats come from a queue model of the lane-splitting rules.
`timescale 1ns/1ps
module tb_axis_fifo_downsizer;

    localparam int DW  = 64;
    localparam int UW  = 8;
    localparam int R   = 4;
    localparam int AW  = 2;
    localparam int KW  = DW / 8;
    localparam int WDW = R * DW;
    localparam int WKW = R * KW;
    localparam int WUW = R * UW;
    localparam int NW  = DW + KW + UW + 1;

    typedef struct {
        logic [WDW-1:0] d;
        logic [WKW-1:0] k;
        logic [WUW-1:0] u;
        logic           l;
    } wbeat_t;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
        bit            eol;
    } nbeat_t;

    typedef struct {
        logic [WKW-1:0] k;
        logic           l;
        int             exp_n;
        logic [KW-1:0]  exp_last_keep;
        logic           exp_last_tlast;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [WDW-1:0] write_tdata;
    logic [WKW-1:0] write_tkeep;
    logic [WUW-1:0] write_tuser;
    logic           write_tvalid;
    logic           write_tlast;
    logic           write_tready;
    logic [DW-1:0]  read_tdata;
    logic [KW-1:0]  read_tkeep;
    logic [UW-1:0]  read_tuser;
    logic           read_tvalid;
    logic           read_tlast;
    logic           read_tready;
`ifdef AXIS_FIFO_DOWNSIZER_COUNT_EN
    logic [AW:0]    count;
`endif

    axis_fifo_downsizer #(
        .AXIS_DATA_WIDTH  (DW),
        .AXIS_TUSER_WIDTH (UW),
        .RATIO            (R),
        .ADDR_WIDTH       (AW)
    ) dut (
        .aclk         (clk),
        .reset        (rst),
        .write_tdata  (write_tdata),
        .write_tkeep  (write_tkeep),
        .write_tuser  (write_tuser),
        .write_tvalid (write_tvalid),
        .write_tlast  (write_tlast),
        .write_tready (write_tready),
        .read_tdata   (read_tdata),
        .read_tkeep   (read_tkeep),
        .read_tuser   (read_tuser),
        .read_tvalid  (read_tvalid),
        .read_tlast   (read_tlast),
        .read_tready  (read_tready)
`ifdef AXIS_FIFO_DOWNSIZER_COUNT_EN
        ,
        .count        (count)
`endif
    );

    always #5 clk = ~clk;

    int       checks = 0;
    int       errors = 0;
    wbeat_t   src_q[$];
    nbeat_t   exp_q[$];
    int       cyc = 0;
    int       rd_count = 0;
    int       bubbles = 0;
    int       first_pop_cyc = -1;
    int       wr_cyc = -1;
    int       rmode = 1;
    int       wrand = 100;
    bit       watch_bubble = 0;
    bit       snap_ok = 0;
    logic [NW-1:0] snap;
    logic [KW-1:0] last_rd_keep;
    logic          last_rd_tlast;
    vec_t     vecs[7];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [WDW-1:0] rand_wide();
        logic [WDW-1:0] v;
        for (int i = 0; i < WDW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // A tlast beat ends at its highest lane with any kept byte (lane 0 if none)
    task automatic expand(input wbeat_t b);
        int n;
        nbeat_t nb;
        n = R;
        if (b.l) begin
            n = 1;
            for (int i = 0; i < R; i++)
                if (b.k[i*KW +: KW] != '0) n = i + 1;
        end
        for (int i = 0; i < n; i++) begin
            nb.d   = b.d[i*DW +: DW];
            nb.k   = b.k[i*KW +: KW];
            nb.u   = b.u[i*UW +: UW];
            nb.l   = b.l && (i == n - 1);
            nb.eol = (i == n - 1);
            exp_q.push_back(nb);
        end
    endtask

    task automatic step();
        nbeat_t e;
        wbeat_t b;
        bit     wfire;
        logic [NW-1:0] cur;
        if (!write_tvalid && src_q.size() > 0 &&
            $urandom_range(99) < wrand) begin
            write_tvalid = 1'b1;
            write_tdata  = src_q[0].d;
            write_tkeep  = src_q[0].k;
            write_tuser  = src_q[0].u;
            write_tlast  = src_q[0].l;
        end
        case (rmode)
            0:       read_tready = 1'b0;
            1:       read_tready = 1'b1;
            2:       read_tready = !read_tready;
            default: read_tready = 1'($urandom_range(1));
        endcase
        cur = {read_tdata, read_tkeep, read_tuser, read_tlast};
        if (snap_ok) chk("stall_hold", {read_tvalid, cur}, {1'b1, snap});
        snap_ok = 0;
        if (watch_bubble && exp_q.size() > 0 && read_tready && !read_tvalid)
            bubbles++;
        if (read_tvalid && read_tready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL extra_beat: got beat %h expected none", cur);
            end else begin
                checks--;
                e = exp_q.pop_front();
                chk("narrow_beat", cur, {e.d, e.k, e.u, e.l});
                rd_count++;
                last_rd_keep  = read_tkeep;
                last_rd_tlast = read_tlast;
                if (e.eol && first_pop_cyc < 0) first_pop_cyc = cyc;
            end
        end else if (read_tvalid) begin
            snap    = cur;
            snap_ok = 1;
        end
        wfire = write_tvalid && write_tready;
        if (wfire) begin
            b = src_q.pop_front();
            expand(b);
            wr_cyc = cyc;
        end
        @(negedge clk);
        if (wfire) write_tvalid = 1'b0;
        cyc++;
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout: pending src %0d exp %0d, required 0 0",
                     src_q.size(), exp_q.size());
        end
        repeat (3) step();
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        write_tvalid = 1'b0;
        read_tready  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        src_q.delete();
        exp_q.delete();
        snap_ok = 0;
    endtask

    task automatic push(input logic [WKW-1:0] k, input logic l);
        wbeat_t b;
        b.d = rand_wide();
        b.k = k;
        b.u = WUW'($urandom);
        b.l = l;
        src_q.push_back(b);
    endtask

    initial begin
        int rd0;
        int n;
        vecs[0] = '{k: 32'h0000FFFF, l: 1'b1, exp_n: 2,
                    exp_last_keep: 8'hFF, exp_last_tlast: 1'b1};
        vecs[1] = '{k: 32'h00000000, l: 1'b1, exp_n: 1,
                    exp_last_keep: 8'h00, exp_last_tlast: 1'b1};
        vecs[2] = '{k: 32'hFFFFFFFF, l: 1'b1, exp_n: 4,
                    exp_last_keep: 8'hFF, exp_last_tlast: 1'b1};
        vecs[3] = '{k: 32'h0F000000, l: 1'b1, exp_n: 4,
                    exp_last_keep: 8'h0F, exp_last_tlast: 1'b1};
        vecs[4] = '{k: 32'h000000F0, l: 1'b1, exp_n: 1,
                    exp_last_keep: 8'hF0, exp_last_tlast: 1'b1};
        vecs[5] = '{k: 32'h00FF0000, l: 1'b1, exp_n: 3,
                    exp_last_keep: 8'hFF, exp_last_tlast: 1'b1};
        vecs[6] = '{k: 32'h000000FF, l: 1'b0, exp_n: 4,
                    exp_last_keep: 8'h00, exp_last_tlast: 1'b0};

        write_tdata  = '0;
        write_tkeep  = '0;
        write_tuser  = '0;
        write_tlast  = 1'b0;
        write_tvalid = 1'b0;
        read_tready  = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        do_reset();
        chk("reset_rvalid", read_tvalid, 1'b0);
        chk("reset_wready", write_tready, 1'b1);
`ifdef AXIS_FIFO_DOWNSIZER_COUNT_EN
        chk("reset_count", count, 0);
`endif

        // Table rows: one wide beat each, sink always ready
        rmode = 1;
        wrand = 100;
        for (int v = 0; v < 7; v++) begin
            rd0 = rd_count;
            push(vecs[v].k, vecs[v].l);
            step();
            chk("first_word_latency", read_tvalid, 1'b1);
            run_until_idle(40);
            chk("row_beats", rd_count - rd0, vecs[v].exp_n);
            chk("row_last_keep", last_rd_keep, vecs[v].exp_last_keep);
            chk("row_last_tlast", last_rd_tlast, vecs[v].exp_last_tlast);
        end

        // Three-beat packet streams out with no idle cycles
        rd0 = rd_count;
        bubbles = 0;
        watch_bubble = 1;
        push('1, 1'b0);
        push('1, 1'b0);
        push('1, 1'b1);
        run_until_idle(60);
        watch_bubble = 0;
        chk("no_bubble", bubbles, 0);
        chk("burst_beats", rd_count - rd0, 12);

        // Fill to full with the sink stalled; fifth beat waits for a pop
        rmode = 0;
        for (int i = 0; i < 5; i++) push('1, i == 4);
        repeat (8) step();
        chk("full_wready", write_tready, 1'b0);
        chk("fifth_held", src_q.size(), 1);
`ifdef AXIS_FIFO_DOWNSIZER_COUNT_EN
        chk("full_count", count, 4);
`endif
        first_pop_cyc = -1;
        rmode = 1;
        run_until_idle(80);
        chk("write_after_pop", wr_cyc, first_pop_cyc + 1);

        // Sink toggling ready: outputs must hold through each stall
        rmode = 2;
        push('1, 1'b0);
        push(32'h00FFFFFF, 1'b1);
        run_until_idle(80);

        // Reset after two of four lanes have been read
        rmode = 1;
        rd0 = rd_count;
        push('1, 1'b1);
        n = 0;
        while (rd_count - rd0 < 2 && n < 20) begin
            step();
            n++;
        end
        chk("mid_reads", rd_count - rd0, 2);
        do_reset();
        chk("midrst_rvalid", read_tvalid, 1'b0);
        chk("midrst_wready", write_tready, 1'b1);
`ifdef AXIS_FIFO_DOWNSIZER_COUNT_EN
        chk("midrst_count", count, 0);
`endif
        rd0 = rd_count;
        push(32'h0000FFFF, 1'b1);
        run_until_idle(40);
        chk("post_reset_beats", rd_count - rd0, 2);

        // Random traffic on both sides
        rmode = 3;
        wrand = 60;
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(3))
                0:       push('0, 1'($urandom_range(1)));
                1:       push('1, 1'($urandom_range(1)));
                default: push(WKW'($urandom), ($urandom_range(2) == 0));
            endcase
        end
        run_until_idle(20000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
